hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 14 +
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and default memory timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam int TIMEOUT_DEF = 256;
  localparam int TMR_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // count up on inc until every bit is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes,
// data-memory wait stalls with timeout, and stall/flush statistics.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rs1_D,
  input  logic [4:0]       i_rs2_D,
  input  logic [4:0]       i_rd_E,
  input  logic             i_memread_E,
  input  logic             i_pcsrc_E,
  input  logic             i_dmem_req_M,
  input  logic             i_dmem_ready,
  output logic             o_stall_F,
  output logic             o_stall_D,
  output logic             o_stall_E,
  output logic             o_stall_M,
  output logic             o_flush_D,
  output logic             o_flush_E,
  output logic             o_flush_W,
  output logic             o_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [TMR_W-1:0] LP_TMO = TMR_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             r_err;
  logic             w_err_nxt;

  logic w_memwait;
  logic w_redirect;
  logic w_loaduse;
  logic w_sF, w_sD, w_sE, w_sM;
  logic w_fD, w_fE, w_fW;
  logic w_flush_inc;

  assign w_memwait  = i_dmem_req_M & ~i_dmem_ready;
  assign w_redirect = i_pcsrc_E;
  assign w_loaduse  = i_memread_E & (i_rd_E != 5'd0) &
                      ((i_rd_E == i_rs1_D) | (i_rd_E == i_rs2_D));

  // state, timeout timer and sticky error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_tmr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // next state and stall/flush decode
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_err_nxt   = r_err;
    w_sF = 1'b0;
    w_sD = 1'b0;
    w_sE = 1'b0;
    w_sM = 1'b0;
    w_fD = 1'b0;
    w_fE = 1'b0;
    w_fW = 1'b0;
    unique case (r_state)
      RUN: begin
        w_tmr_nxt = '0;
        if (w_memwait) begin
          {w_sF, w_sD, w_sE, w_sM} = 4'hF;
          w_fW        = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_tmr_nxt   = TMR_W'(1);
        end else if (w_redirect) begin
          w_fD = 1'b1;
          w_fE = 1'b1;
        end else if (w_loaduse) begin
          w_sF = 1'b1;
          w_sD = 1'b1;
          w_fE = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ready) begin
          w_state_nxt = RUN;
          w_tmr_nxt   = '0;
        end else begin
          {w_sF, w_sD, w_sE, w_sM} = 4'hF;
          w_fW = 1'b1;
          if (r_tmr == LP_TMO) begin
            w_state_nxt = ERROR;
            w_err_nxt   = 1'b1;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
      end
      ERROR: begin
        {w_sF, w_sD, w_sE, w_sM} = 4'hF;
        w_fW      = 1'b1;
        w_err_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // reset holds every control output low regardless of inputs
  assign o_stall_F = i_rst_n & w_sF;
  assign o_stall_D = i_rst_n & w_sD;
  assign o_stall_E = i_rst_n & w_sE;
  assign o_stall_M = i_rst_n & w_sM;
  assign o_flush_D = i_rst_n & w_fD;
  assign o_flush_E = i_rst_n & w_fE;
  assign o_flush_W = i_rst_n & w_fW;
  assign o_err     = r_err;

  assign w_flush_inc = o_flush_D | o_flush_E;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (o_stall_F),
    .count (o_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (w_flush_inc),
    .count (o_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
// Small TIMEOUT and CNT_W make timeout and saturation reachable.
module tb_hazard_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] ALL  = 7'b1111001;
  localparam logic [6:0] BUB  = 7'b1100010;
  localparam logic [6:0] RED  = 7'b0000110;

  logic          clk;
  logic          rst_n;
  logic [4:0]    rs1, rs2, rd;
  logic          mr, pc, req, rdy;
  logic          sF, sD, sE, sM, fD, fE, fW, err;
  logic [CW-1:0] scnt, fcnt;
  logic [6:0]    w_obs;

  int n_run;
  int n_fail;
  logic [6:0] q[$];

  hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rs1_D      (rs1),
    .i_rs2_D      (rs2),
    .i_rd_E       (rd),
    .i_memread_E  (mr),
    .i_pcsrc_E    (pc),
    .i_dmem_req_M (req),
    .i_dmem_ready (rdy),
    .o_stall_F    (sF),
    .o_stall_D    (sD),
    .o_stall_E    (sE),
    .o_stall_M    (sM),
    .o_flush_D    (fD),
    .o_flush_E    (fE),
    .o_flush_W    (fW),
    .o_err        (err),
    .o_stall_cnt  (scnt),
    .o_flush_cnt  (fcnt)
  );

  assign w_obs = {sF, sD, sE, sM, fD, fE, fW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cnts(input string tag, input int s, input int f,
                      input logic e);
    chk({tag, "_scnt"}, 32'(scnt), 32'(s));
    chk({tag, "_fcnt"}, 32'(fcnt), 32'(f));
    chk({tag, "_err"}, 32'(err), 32'(e));
  endtask

  // called at posedge+1; checks at negedge; returns at posedge+1
  task automatic step(input string tag, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d,
                      input logic m, input logic p, input logic rq,
                      input logic ry, input logic [6:0] ev);
    logic [6:0] e;
    rs1 = a; rs2 = b; rd = d;
    mr = m; pc = p; req = rq; rdy = ry;
    q.push_back(ev);
    @(negedge clk);
    e = q.pop_front();
    chk(tag, 32'(w_obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [6:0] ev);
    step(tag, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev);
  endtask

  task automatic lu(input string tag);
    step(tag, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, BUB);
  endtask

  task automatic mw(input string tag, input logic ry,
                    input logic [6:0] ev);
    step(tag, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ry, ev);
  endtask

  // assert reset with hostile inputs, check it wins, then release
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    rs1 = 5'd3; rs2 = 5'd3; rd = 5'd3;
    mr = 1'b1; pc = 1'b1; req = 1'b1; rdy = 1'b0;
    #1;
    chk({tag, "_outs"}, 32'(w_obs), 32'(NONE));
    cnts(tag, 0, 0, 1'b0);
    rs1 = '0; rs2 = '0; rd = '0;
    mr = 1'b0; pc = 1'b0; req = 1'b0; rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    do_reset("rst0");
    idle("idle0", NONE);

    // load-use on rs2
    step("lu_rs2", 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, BUB);
    idle("lu_after", NONE);
    cnts("lu", 1, 1, 1'b0);

    // load to x0 is never a hazard
    step("lu_x0", 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
    cnts("x0", 1, 1, 1'b0);

    // redirect beats load-use
    step("red_lu", 5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, RED);
    cnts("red", 1, 2, 1'b0);

    // load-use on rs1
    step("lu_rs1", 5'd3, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, BUB);
    cnts("lu1", 2, 3, 1'b0);

    // memory wait 3 cycles, redirect+loaduse masked
    do_reset("rst1");
    step("mw_run", 5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, ALL);
    mw("mw_1", 1'b0, ALL);
    mw("mw_2", 1'b0, ALL);
    mw("mw_rdy", 1'b1, NONE);
    cnts("mw", 3, 0, 1'b0);
    idle("mw_idle", NONE);
    lu("mw_lu");

    // ready on the cycle where timer hits TIMEOUT still returns to RUN
    do_reset("rst2");
    mw("edge_run", 1'b0, ALL);
    for (int i = 1; i < TMO; i++) mw("edge_wait", 1'b0, ALL);
    mw("edge_rdy", 1'b1, NONE);
    chk("edge_err", 32'(err), 32'(0));
    idle("edge_idle", NONE);

    // timeout into ERROR
    do_reset("rst3");
    mw("to_run", 1'b0, ALL);
    for (int i = 1; i < TMO; i++) mw("to_wait", 1'b0, ALL);
    chk("to_err_pre", 32'(err), 32'(0));
    mw("to_last", 1'b0, ALL);
    chk("to_err", 32'(err), 32'(1));
    mw("err_hold", 1'b1, ALL);
    step("err_red", 5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, ALL);
    chk("err_sticky", 32'(err), 32'(1));
    do_reset("rst_err");
    lu("post_err_lu");
    idle("post_err_idle", NONE);

    // counter saturation
    do_reset("rst4");
    for (int i = 0; i < 20; i++) begin
      lu("sat_lu");
      if (i == 13) cnts("sat14", 14, 14, 1'b0);
    end
    cnts("sat", 15, 15, 1'b0);
    idle("sat_idle", NONE);
    cnts("sat_hold", 15, 15, 1'b0);

    chk("sb_empty", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
